// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-stage definitions: NOP encoding, fetch FSM state encoding and
// the default reset vector. The decode stage uses NOP for its bubbles too.
package ifetch_unit_pkg;

  localparam logic [31:0] NOP                  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// Prefetch buffer for {instr, nextpc} pairs. Flush wins over push; a push into
// a full buffer is accepted when the head is popped in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] advance(input logic [PW-1:0] ptr);
    return (ptr == LAST) ? '0 : ptr + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= advance(wr_ptr);
      if (do_pop)  rd_ptr <= advance(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage holds data only, so it needs no reset
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding req/ack memory fetch feeding a small
// prefetch FIFO. Define IFETCH_PERF_EN to add the FetchCount/FlushCount ports.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        Stall,
  input  logic        UnconditionalBranch,
  input  logic [31:0] UnconditionalBranchTarget,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] NextPCOut,
  output logic        InstValid
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] FlushCount
`endif
);

  localparam int          CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

  fetch_state_e  state, state_next;
  logic [31:0]   pc, pc_next;
  logic [31:0]   addr, addr_next;
  logic [31:0]   pc_plus4;
  logic          push;
  logic          drop_word;
  logic          pop_head;
  logic          jump_take;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [63:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;

  assign pc_plus4    = pc + 32'd4;
  assign pop_head    = !fifo_empty && !Stall;
  assign jump_take   = UnconditionalBranch && pop_head && !BranchTaken;
  assign redirect    = BranchTaken || jump_take;
  assign redirect_pc = BranchTaken ? word_align(BranchTarget)
                                   : word_align(UnconditionalBranchTarget);

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clk  (Clk),
    .rst_n(ResetN),
    .push (push),
    .pop  (pop_head),
    .flush(redirect),
    .din  ({IMemData, pc_plus4}),
    .head (fifo_head),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign Instruction = fifo_empty ? NOP : fifo_head[63:32];
  assign NextPCOut   = fifo_empty ? 32'h0 : fifo_head[31:0];
  assign InstValid   = !fifo_empty;
  assign IMemReq     = (state != IDLE);
  assign IMemAddr    = addr;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state <= IDLE;
      pc    <= RESET_PC;
      addr  <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      addr  <= addr_next;
    end
  end

  // A request, once raised, is never withdrawn; a redirect only decides whether its data is kept
  always_comb begin
    state_next = state;
    pc_next    = pc;
    addr_next  = addr;
    push       = 1'b0;
    drop_word  = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && !fifo_full) begin
          state_next = REQ;
          addr_next  = pc;
        end
      end
      REQ: begin
        if (IMemAck) begin
          state_next = IDLE;
          if (redirect) begin
            drop_word = 1'b1;
          end else begin
            push    = 1'b1;
            pc_next = pc_plus4;
          end
        end else if (redirect) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (IMemAck) begin
          state_next = IDLE;
          drop_word  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (redirect) pc_next = redirect_pc;
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] flushed;

  // A head popped in the redirect cycle was delivered, so it is not counted as flushed
  always_comb begin
    flushed = 32'd0;
    if (redirect)  flushed = 32'(fifo_count) - 32'(pop_head);
    if (drop_word) flushed = flushed + 32'd1;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      FetchCount <= 32'd0;
      FlushCount <= 32'd0;
    end else begin
      FetchCount <= sat_add(FetchCount, {31'd0, push});
      FlushCount <= sat_add(FlushCount, flushed);
    end
  end
`else
  logic unused_perf;
  assign unused_perf = ^{fifo_count, drop_word};
`endif

endmodule
